// File: rtl/seq_pkg.sv
// Shared state encodings for the serial 1101 transmitter/detector family.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial output bundle for seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int W  = 4,
  parameter int RW = 4
);
  logic          load_valid;
  logic [W-1:0]  pattern;
  logic [RW-1:0] repeat_cnt;
  logic          load_ready;
  logic          out;
  logic          bit_valid;
  logic          busy;
  logic          done;

  modport master (
    output load_valid, pattern, repeat_cnt,
    input  load_ready, out, bit_valid, busy, done
  );

  modport slave (
    input  load_valid, pattern, repeat_cnt,
    output load_ready, out, bit_valid, busy, done
  );
endinterface

// File: rtl/piso_rotate_reg.sv
// Parallel-load shift register that rotates left so the pattern survives repeats.
module piso_rotate_reg #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_rot,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_sr <= '0;
    else if (i_load)
      r_sr <= i_data;
    else if (i_rot)
      r_sr <= {r_sr[W-2:0], r_sr[W-1]};
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends repeat_cnt+1 MSB-first copies of a W-bit
// pattern with GAP idle cycles between copies, then pulses done.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int W   = 4,
  parameter int RW  = 4,
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int BW = $clog2(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_bit_idx, w_bit_idx_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [RW-1:0]   r_rep_left, w_rep_left_nxt;
  logic            r_done, w_done_nxt;
  logic            w_load, w_rot, w_msb;

  piso_rotate_reg #(.W(W)) u_sr (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_load),
    .i_data  (bus.pattern),
    .i_rot   (w_rot),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_rep_left <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_rep_left <= w_rep_left_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_rep_left_nxt = r_rep_left;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_rot          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          w_load         = 1'b1;
          w_state_nxt    = ST_SHIFT;
          w_bit_idx_nxt  = BIT_LAST;
          w_rep_left_nxt = bus.repeat_cnt;
        end
      end
      ST_SHIFT: begin
        // Rotating on every bit, including bit 0, restores the pattern for the next copy.
        w_rot = 1'b1;
        if (r_bit_idx == '0) begin
          if (r_rep_left == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_rep_left_nxt = r_rep_left - RW'(1);
            w_bit_idx_nxt  = BIT_LAST;
            if (GAP > 0) begin
              w_state_nxt   = ST_GAP;
              w_gap_cnt_nxt = GAP_LAST;
            end
          end
        end else begin
          w_bit_idx_nxt = r_bit_idx - BW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0)
          w_state_nxt = ST_SHIFT;
        else
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.load_ready = (r_state == ST_IDLE);
  assign bus.bit_valid  = (r_state == ST_SHIFT);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.out        = (r_state == ST_SHIFT) & w_msb;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=1, one with GAP=0.
module tb_seq_pattern_tx;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_pattern_tx_if #(.W(4), .RW(4)) bus0 ();
  seq_pattern_tx_if #(.W(4), .RW(4)) bus1 ();

  seq_pattern_tx #(.W(4), .RW(4), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seq_pattern_tx #(.W(4), .RW(4), .GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          gap1;
    logic [3:0]  pat;
    logic [3:0]  rc;
    int unsigned len;
    logic [31:0] exp_out;
    logic [31:0] exp_bv;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit g, logic v, logic [3:0] p, logic [3:0] rc);
    if (g) begin
      bus1.load_valid = v; bus1.pattern = p; bus1.repeat_cnt = rc;
    end else begin
      bus0.load_valid = v; bus0.pattern = p; bus0.repeat_cnt = rc;
    end
  endtask

  function automatic logic s_out(bit g);   return g ? bus1.out        : bus0.out;        endfunction
  function automatic logic s_bv(bit g);    return g ? bus1.bit_valid  : bus0.bit_valid;  endfunction
  function automatic logic s_busy(bit g);  return g ? bus1.busy       : bus0.busy;       endfunction
  function automatic logic s_done(bit g);  return g ? bus1.done       : bus0.done;       endfunction
  function automatic logic s_rdy(bit g);   return g ? bus1.load_ready : bus0.load_ready; endfunction

  task automatic run_vec(int i);
    bit g;
    g = vecs[i].gap1;
    @(negedge clk);
    chk($sformatf("v%0d_ready_before", i), 32'(s_rdy(g)), 32'd1);
    drive(g, 1'b1, vecs[i].pat, vecs[i].rc);
    @(negedge clk);
    drive(g, 1'b0, 4'h0, 4'h0);
    for (int unsigned k = 0; k < vecs[i].len; k++) begin
      chk($sformatf("v%0d_out_b%0d", i, k), 32'(s_out(g)), 32'(vecs[i].exp_out[vecs[i].len-1-k]));
      chk($sformatf("v%0d_bv_b%0d", i, k), 32'(s_bv(g)), 32'(vecs[i].exp_bv[vecs[i].len-1-k]));
      chk($sformatf("v%0d_busy_b%0d", i, k), 32'(s_busy(g)), 32'd1);
      chk($sformatf("v%0d_done_b%0d", i, k), 32'(s_done(g)), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("v%0d_done", i), 32'(s_done(g)), 32'd1);
    chk($sformatf("v%0d_ready_done", i), 32'(s_rdy(g)), 32'd1);
    chk($sformatf("v%0d_busy_done", i), 32'(s_busy(g)), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_clear", i), 32'(s_done(g)), 32'd0);
  endtask

  initial begin
    bit          saw_done;
    bit          saw_bv;
    int unsigned n;
    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b1, 4'b1101, 4'd0, 4,  32'b1101,           32'b1111};
    vecs[1] = '{1'b1, 4'b1101, 4'd1, 9,  32'b110101101,      32'b111101111};
    vecs[2] = '{1'b0, 4'b1011, 4'd2, 12, 32'b101110111011,   32'b111111111111};
    vecs[3] = '{1'b1, 4'b1000, 4'd0, 4,  32'b1000,           32'b1111};
    vecs[4] = '{1'b0, 4'b0110, 4'd1, 8,  32'b01100110,       32'b11111111};
    vecs[5] = '{1'b1, 4'b0001, 4'd2, 14, 32'b00010000100001, 32'b11110111101111};

    // Reset held with load_valid asserted: nothing may start.
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'b1101, 4'd0);
    drive(1'b0, 1'b1, 4'b1101, 4'd0);
    #12;
    chk("rst_out1",   32'(bus1.out),        32'd0);
    chk("rst_busy1",  32'(bus1.busy),       32'd0);
    chk("rst_ready1", 32'(bus1.load_ready), 32'd1);
    chk("rst_done1",  32'(bus1.done),       32'd0);
    chk("rst_out0",   32'(bus0.out),        32'd0);
    chk("rst_busy0",  32'(bus0.busy),       32'd0);
    chk("rst_ready0", 32'(bus0.load_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_bv1", 32'(bus1.bit_valid), 32'd0);
    chk("post_rst_bv0", 32'(bus0.bit_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Load attempted while busy is dropped; a held request is taken in the done cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'b1101, 4'd0);
    @(negedge clk);
    chk("bl_b0_out", 32'(bus1.out), 32'd1);
    drive(1'b1, 1'b1, 4'b0000, 4'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bl_b%0d_out", k), 32'(bus1.out), (k == 2) ? 32'd0 : 32'd1);
      chk($sformatf("bl_b%0d_ready", k), 32'(bus1.load_ready), 32'd0);
    end
    @(negedge clk);
    chk("bl_done",  32'(bus1.done),       32'd1);
    chk("bl_ready", 32'(bus1.load_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    chk("bl_new_bv",   32'(bus1.bit_valid), 32'd1);
    chk("bl_new_out",  32'(bus1.out),       32'd0);
    chk("bl_new_done", 32'(bus1.done),      32'd0);
    n = 0;
    for (int unsigned c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus1.done) begin
        n = c;
        break;
      end
      chk($sformatf("bl_new_out_c%0d", c), 32'(bus1.out), 32'd0);
    end
    chk("bl_new_len", 32'(n), 32'd4);

    // Asynchronous abort after the third bit.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'b1101, 4'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    chk("ab_b0", 32'(bus1.out), 32'd1);
    @(negedge clk);
    chk("ab_b1", 32'(bus1.out), 32'd1);
    @(negedge clk);
    chk("ab_b2", 32'(bus1.out), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("ab_out",   32'(bus1.out),        32'd0);
    chk("ab_bv",    32'(bus1.bit_valid),  32'd0);
    chk("ab_busy",  32'(bus1.busy),       32'd0);
    chk("ab_ready", 32'(bus1.load_ready), 32'd1);
    saw_done = 1'b0;
    saw_bv   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus1.done) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus1.done) saw_done = 1'b1;
      if (bus1.bit_valid) saw_bv = 1'b1;
    end
    chk("ab_no_done",   32'(saw_done),        32'd0);
    chk("ab_no_resume", 32'(saw_bv),          32'd0);
    chk("ab_rel_ready", 32'(bus1.load_ready), 32'd1);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
